// File: rtl/text_console_writer.sv
// text_console_writer
//   Character-stream front end for the VGA text buffer write port. Bytes arrive on a
//   valid/ready stream and are turned into text-buffer writes while a cursor is tracked.
//   Printable bytes are written at the cursor. LF, CR, BS, TAB and FF are interpreted as
//   control codes. When the cursor advances to a new line, that row is cleared so the
//   screen scrolls as a ring of rows. After reset, or after FF, the whole screen is
//   cleared to spaces.
//
// Ports
//   busclk    in   1    clock, all logic on posedge
//   rst       in   1    asynchronous active-high reset
//   in_data   in   8    byte to print / control code
//   in_valid  in   1    in_data valid
//   in_ready  out  1    block can accept (only while idle); transfer = in_valid & in_ready
//   waddr     out  15   buffer address {1'b0, row, col}
//   wdata     out  8    byte to write
//   wr_en     out  1    write strobe (one write per cycle high)
//   cur_row   out  6    cursor row
//   cur_col   out  8    cursor column, 0..COLS-1
module text_console_writer #(
  parameter int COLS     = 160,
  parameter int ROWS     = 64,
  parameter int COL_BITS = 8,
  parameter int ROW_BITS = 6
) (
  input  logic                         busclk,
  input  logic                         rst,
  input  logic [7:0]                   in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [ROW_BITS+COL_BITS:0]   waddr,
  output logic [7:0]                   wdata,
  output logic                         wr_en,
  output logic [ROW_BITS-1:0]          cur_row,
  output logic [COL_BITS-1:0]          cur_col
);

  localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(COLS - 1);
  localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(ROWS - 1);
  localparam logic [COL_BITS:0]   COLS_EXT = (COL_BITS + 1)'(COLS);
  localparam logic [7:0]          SPACE    = 8'h20;

  typedef enum logic [1:0] {
    CLR_ALL  = 2'd0,
    IDLE     = 2'd1,
    CLR_LINE = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [ROW_BITS-1:0]         clr_row_q, clr_row_d;
  logic [COL_BITS-1:0]         clr_col_q, clr_col_d;
  logic [ROW_BITS-1:0]         row_q, row_d;
  logic [COL_BITS-1:0]         col_q, col_d;
  logic [ROW_BITS+COL_BITS:0]  waddr_q, waddr_d;
  logic [7:0]                  wdata_q, wdata_d;
  logic                        wr_en_q, wr_en_d;
  logic                        in_ready_q, in_ready_d;

  logic                        accept_s;
  logic                        line_adv_s;
  logic [ROW_BITS-1:0]         next_row_s;
  logic [COL_BITS:0]           tab_col_s;

  assign accept_s   = in_valid & in_ready_q;
  // Rows form a ring: the row after the last one is row 0.
  assign next_row_s = (row_q == LAST_ROW) ? '0 : row_q + ROW_BITS'(1);
  // Next tab stop (multiple of 8); one extra bit so a stop past the last column is visible.
  assign tab_col_s  = {1'b0, col_q | COL_BITS'(7)} + (COL_BITS + 1)'(1);

  // Next-state, cursor and write-port computation.
  always_comb begin
    state_d    = state_q;
    clr_row_d  = clr_row_q;
    clr_col_d  = clr_col_q;
    row_d      = row_q;
    col_d      = col_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    wr_en_d    = 1'b0;
    line_adv_s = 1'b0;

    case (state_q)
      CLR_ALL: begin
        wr_en_d = 1'b1;
        waddr_d = {1'b0, clr_row_q, clr_col_q};
        wdata_d = SPACE;
        if (clr_col_q == LAST_COL) begin
          clr_col_d = '0;
          if (clr_row_q == LAST_ROW) begin
            clr_row_d = '0;
            row_d     = '0;
            col_d     = '0;
            state_d   = IDLE;
          end else begin
            clr_row_d = clr_row_q + ROW_BITS'(1);
          end
        end else begin
          clr_col_d = clr_col_q + COL_BITS'(1);
        end
      end

      IDLE: begin
        if (accept_s) begin
          case (in_data)
            8'h0A: begin
              line_adv_s = 1'b1;
            end
            8'h0D: begin
              col_d = '0;
            end
            8'h08: begin
              if (col_q != '0) begin
                col_d   = col_q - COL_BITS'(1);
                wr_en_d = 1'b1;
                waddr_d = {1'b0, row_q, col_q - COL_BITS'(1)};
                wdata_d = SPACE;
              end else begin
                col_d = col_q;
              end
            end
            8'h09: begin
              if (tab_col_s >= COLS_EXT) begin
                line_adv_s = 1'b1;
              end else begin
                col_d = tab_col_s[COL_BITS-1:0];
              end
            end
            8'h0C: begin
              row_d     = '0;
              col_d     = '0;
              clr_row_d = '0;
              clr_col_d = '0;
              state_d   = CLR_ALL;
            end
            default: begin
              if ((in_data >= 8'h20) && (in_data <= 8'h7E)) begin
                wr_en_d = 1'b1;
                waddr_d = {1'b0, row_q, col_q};
                wdata_d = in_data;
                // Writing the last column wraps straight into a line advance.
                if (col_q == LAST_COL) begin
                  line_adv_s = 1'b1;
                end else begin
                  col_d = col_q + COL_BITS'(1);
                end
              end else begin
                col_d = col_q;
              end
            end
          endcase

          if (line_adv_s) begin
            row_d     = next_row_s;
            col_d     = '0;
            clr_col_d = '0;
            state_d   = CLR_LINE;
          end else begin
            clr_col_d = clr_col_q;
          end
        end else begin
          state_d = IDLE;
        end
      end

      CLR_LINE: begin
        // Cursor row already points at the new line being cleared.
        wr_en_d = 1'b1;
        waddr_d = {1'b0, row_q, clr_col_q};
        wdata_d = SPACE;
        if (clr_col_q == LAST_COL) begin
          clr_col_d = '0;
          state_d   = IDLE;
        end else begin
          clr_col_d = clr_col_q + COL_BITS'(1);
        end
      end

      default: begin
        clr_row_d = '0;
        clr_col_d = '0;
        state_d   = CLR_ALL;
      end
    endcase

    in_ready_d = (state_d == IDLE);
  end

  // State, cursor and registered outputs.
  always_ff @(posedge busclk or posedge rst) begin
    if (rst) begin
      state_q    <= CLR_ALL;
      clr_row_q  <= '0;
      clr_col_q  <= '0;
      row_q      <= '0;
      col_q      <= '0;
      waddr_q    <= '0;
      wdata_q    <= 8'h00;
      wr_en_q    <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_row_q  <= clr_row_d;
      clr_col_q  <= clr_col_d;
      row_q      <= row_d;
      col_q      <= col_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      wr_en_q    <= wr_en_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready = in_ready_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign wr_en    = wr_en_q;
  assign cur_row  = row_q;
  assign cur_col  = col_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Testbench for text_console_writer. Expected writes are pushed to a scoreboard queue
// as stimulus is driven and popped by a monitor whenever wr_en is seen high.
module tb_text_console_writer;

  logic        busclk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] waddr;
  logic [7:0]  wdata;
  logic        wr_en;
  logic [5:0]  cur_row;
  logic [7:0]  cur_col;

  int n_checks = 0;
  int n_fail   = 0;
  int row_m    = 0;
  int col_m    = 0;
  logic [22:0] exp_q[$];
  logic [22:0] exp_e;

  text_console_writer dut (
    .busclk   (busclk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .waddr    (waddr),
    .wdata    (wdata),
    .wr_en    (wr_en),
    .cur_row  (cur_row),
    .cur_col  (cur_col)
  );

  always #5 busclk = ~busclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_write(input int r, input int c, input logic [7:0] d);
    exp_q.push_back({1'b0, 6'(r), 8'(c), d});
  endtask

  task automatic push_line_clear(input int r);
    for (int c = 0; c < 160; c++) push_write(r, c, 8'h20);
  endtask

  task automatic push_full_clear();
    for (int r = 0; r < 64; r++) push_line_clear(r);
  endtask

  task automatic model_advance();
    row_m = (row_m + 1) % 64;
    col_m = 0;
    push_line_clear(row_m);
  endtask

  // Drive one byte, wait (bounded) for acceptance, update the reference cursor model.
  task automatic send(input logic [7:0] b);
    int waitc = 0;
    int t;
    in_data  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && waitc < 20000) begin
      @(negedge busclk);
      waitc++;
    end
    check("send_ready_timeout", 32'(waitc < 20000), 32'd1);
    if (b >= 8'h20 && b <= 8'h7E) begin
      push_write(row_m, col_m, b);
      col_m++;
      if (col_m == 160) model_advance();
    end else if (b == 8'h0A) begin
      model_advance();
    end else if (b == 8'h0D) begin
      col_m = 0;
    end else if (b == 8'h08) begin
      if (col_m > 0) begin
        col_m--;
        push_write(row_m, col_m, 8'h20);
      end
    end else if (b == 8'h09) begin
      t = (col_m | 7) + 1;
      if (t >= 160) model_advance();
      else col_m = t;
    end else if (b == 8'h0C) begin
      row_m = 0;
      col_m = 0;
      push_full_clear();
    end
    @(negedge busclk);
    in_valid = 1'b0;
    check("cursor_row", 32'(cur_row), 32'(row_m));
    check("cursor_col", 32'(cur_col), 32'(col_m));
  endtask

  task automatic wait_ready(input string tag);
    int waitc = 0;
    while (in_ready !== 1'b1 && waitc < 20000) begin
      @(negedge busclk);
      waitc++;
    end
    check(tag, 32'(waitc < 20000), 32'd1);
  endtask

  // Scoreboard monitor: every observed write must match the oldest expected write.
  always @(negedge busclk) begin
    if (wr_en === 1'b1) begin
      n_checks++;
      assert (exp_q.size() > 0) else begin
        n_fail++;
        $error("FAIL unexpected_write: observed addr 0x%0h data 0x%0h expected no write", waddr, wdata);
      end
      if (exp_q.size() > 0) begin
        exp_e = exp_q.pop_front();
        n_checks++;
        assert ({waddr, wdata} === exp_e) else begin
          n_fail++;
          $error("FAIL write: observed addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                 waddr, wdata, exp_e[22:8], exp_e[7:0]);
        end
      end
    end
  end

  initial begin
    int stall;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // 1: reset values, then full-screen clear after release
    push_full_clear();
    @(negedge busclk);
    @(negedge busclk);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_waddr", 32'(waddr), 32'd0);
    check("rst_wdata", 32'(wdata), 32'd0);
    check("rst_cursor", 32'({cur_row, cur_col}), 32'd0);
    rst = 1'b0;
    wait_ready("init_clear_timeout");
    check("init_cursor", 32'({cur_row, cur_col}), 32'd0);
    @(negedge busclk);
    check("init_clear_count", 32'(exp_q.size()), 32'd0);

    // 2: back-to-back printable bytes
    send(8'h41);
    check("b2b_wr1", 32'(wr_en), 32'd1);
    check("b2b_ready", 32'(in_ready), 32'd1);
    send(8'h42);
    check("b2b_wr2", 32'(wr_en), 32'd1);
    check("b2b_addr2", 32'(waddr), 32'h0001);
    check("b2b_col", 32'(cur_col), 32'd2);

    // 3: fill a line, wrap, stall with held byte
    send(8'h0D);
    check("cr_no_write", 32'(wr_en), 32'd0);
    for (int i = 0; i < 160; i++) send(8'h58);
    in_data  = 8'h41;
    in_valid = 1'b1;
    stall    = 0;
    while (in_ready !== 1'b1 && stall < 1000) begin
      @(negedge busclk);
      stall++;
    end
    check("stall_cycles", 32'(stall), 32'd160);
    check("wrap_cursor", 32'({cur_row, cur_col}), 32'h0100);
    send(8'h41);

    // 4: row ring wrap on LF at row 63
    for (int i = 0; i < 62; i++) send(8'h0A);
    check("row63", 32'(cur_row), 32'd63);
    send(8'h0A);
    wait_ready("lf_wrap_timeout");
    check("lf_wrap_cursor", 32'({cur_row, cur_col}), 32'd0);

    // 5: control codes
    for (int i = 0; i < 5; i++) send(8'h41 + 8'(i));
    send(8'h08);
    check("bs_wr", 32'(wr_en), 32'd1);
    check("bs_addr", 32'(waddr), 32'h0004);
    check("bs_data", 32'(wdata), 32'h20);
    send(8'h0D);
    check("cr_wr", 32'(wr_en), 32'd0);
    send(8'h08);
    check("bs0_wr", 32'(wr_en), 32'd0);
    for (int i = 0; i < 3; i++) send(8'h61 + 8'(i));
    send(8'h09);
    check("tab_wr", 32'(wr_en), 32'd0);
    check("tab_col", 32'(cur_col), 32'd8);
    for (int i = 0; i < 147; i++) send(8'h61 + 8'(i % 26));
    check("col155", 32'(cur_col), 32'd155);
    send(8'h09);
    check("tab_adv_ready", 32'(in_ready), 32'd0);
    send(8'h01);
    check("ignored_wr", 32'(wr_en), 32'd0);
    check("ignored_ready", 32'(in_ready), 32'd1);

    // 6: async reset mid line-clear, then FF
    send(8'h0A);
    for (int i = 0; i < 20; i++) @(negedge busclk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("async_rst_wr_en", 32'(wr_en), 32'd0);
    check("async_rst_ready", 32'(in_ready), 32'd0);
    check("async_rst_waddr", 32'(waddr), 32'd0);
    row_m = 0;
    col_m = 0;
    push_full_clear();
    @(negedge busclk);
    @(negedge busclk);
    rst = 1'b0;
    wait_ready("reclear_timeout");
    @(negedge busclk);
    check("reclear_count", 32'(exp_q.size()), 32'd0);
    send(8'h48);
    send(8'h69);
    send(8'h0A);
    send(8'h21);
    send(8'h0C);
    check("ff_ready", 32'(in_ready), 32'd0);
    wait_ready("ff_timeout");
    @(negedge busclk);
    check("ff_cursor", 32'({cur_row, cur_col}), 32'd0);
    check("ff_clear_count", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
